// File: rtl/ed2_tftlcd_pkg.sv
// Shared definitions for the TFT LCD 8080-style bus writer: FSM states, register map, TIMING layout.
package ed2_tftlcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } lcd_state_e;

  localparam logic [1:0] ADDR_CMD    = 2'd0;
  localparam logic [1:0] ADDR_DATA   = 2'd1;
  localparam logic [1:0] ADDR_TIMING = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam logic [11:0] TIMING_RST = 12'h112;

  localparam int unsigned SETUP_LSB  = 0;
  localparam int unsigned STROBE_LSB = 4;
  localparam int unsigned HOLD_LSB   = 8;

  localparam int unsigned LEVEL_LSB  = 8;
  localparam int unsigned LEVEL_W    = 8;
  localparam int unsigned FULL_BIT   = 1;
  localparam int unsigned BUSY_BIT   = 0;

  localparam int unsigned REPEAT_W   = 16;

endpackage

// File: rtl/ed2_tftlcd_sync_fifo.sv
// Single-clock show-ahead FIFO; DEPTH must be a power of two.
module ed2_tftlcd_sync_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == LW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ed2_tftlcd_bus_writer.sv
// Avalon-MM slave that drains a write FIFO into timed 8080-style LCD write cycles.
// Optional TFTLCD_PIXEL_REPEAT_EN: reg 3 write sets a repeat count for the next DATA push.
module ed2_tftlcd_bus_writer
  import ed2_tftlcd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned TIMING_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic              read_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  output logic              lcd_cs_n,
  output logic              lcd_rs,
  output logic              lcd_wr_n,
  output logic              lcd_rd_n,
  output logic [DATA_W-1:0] lcd_data
);

  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TREG_W = 3 * TIMING_W;
`ifdef TFTLCD_PIXEL_REPEAT_EN
  localparam int unsigned ENTRY_W = 1 + DATA_W + REPEAT_W;
`else
  localparam int unsigned ENTRY_W = 1 + DATA_W;
`endif

  typedef logic [TIMING_W-1:0] tfield_t;

  // Counter reload value for a phase; a zero field still lasts one clock.
  function automatic tfield_t phase_last(input logic [TREG_W-1:0] t, input int unsigned lsb);
    tfield_t f;
    f = t[lsb +: TIMING_W];
    return (f == '0) ? '0 : f - tfield_t'(1);
  endfunction

  logic              wr_acc;
  logic              fifo_sel;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              busy;
  logic [LVL_W-1:0]  level;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] pop_entry;
  logic              pop_rs;
  logic [DATA_W-1:0] pop_data;
  logic              unused_wdata;

  logic [TREG_W-1:0] timing_q;
  logic [TREG_W-1:0] snap_q, snap_d;
  lcd_state_e        state_q, state_d;
  tfield_t           cnt_q, cnt_d;
  logic              cs_n_q, cs_n_d;
  logic              wr_n_q, wr_n_d;
  logic              rs_q, rs_d;
  logic [DATA_W-1:0] data_q, data_d;

  assign wr_acc       = chipselect & ~write_n;
  assign fifo_sel     = wr_acc & ~address[1];
  assign push         = fifo_sel & ~full;
  assign waitrequest  = fifo_sel & full;
  assign busy         = ~empty | (state_q != ST_IDLE);
  assign unused_wdata = ^{1'b0, writedata};

  assign pop_rs   = pop_entry[ENTRY_W-1];
  assign pop_data = pop_entry[ENTRY_W-2 -: DATA_W];

`ifdef TFTLCD_PIXEL_REPEAT_EN
  logic [REPEAT_W-1:0] repeat_q;
  logic [REPEAT_W-1:0] rep_q, rep_d;
  logic [REPEAT_W-1:0] pop_cnt;

  assign pop_cnt    = pop_entry[REPEAT_W-1:0];
  assign push_entry = {address[0], writedata[DATA_W-1:0],
                       address[0] ? repeat_q : REPEAT_W'(1)};

  // Pending repeat count applies to the next DATA push only.
  always_ff @(posedge clk) begin
    if (reset) begin
      repeat_q <= REPEAT_W'(1);
    end else if (wr_acc && address == ADDR_STATUS) begin
      repeat_q <= writedata[REPEAT_W-1:0];
    end else if (push && address[0]) begin
      repeat_q <= REPEAT_W'(1);
    end
  end
`else
  assign push_entry = {address[0], writedata[DATA_W-1:0]};
`endif

  ed2_tftlcd_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (pop_entry),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      timing_q <= TREG_W'(TIMING_RST);
    end else if (wr_acc && address == ADDR_TIMING) begin
      timing_q <= writedata[TREG_W-1:0];
    end
  end

  always_comb begin
    readdata = '0;
    if (chipselect && !read_n) begin
      case (address)
        ADDR_TIMING: readdata = 32'(timing_q);
        ADDR_STATUS: begin
          readdata[LEVEL_LSB +: LEVEL_W] = LEVEL_W'(level);
          readdata[FULL_BIT]             = full;
          readdata[BUSY_BIT]             = busy;
        end
        default: readdata = '0;
      endcase
    end
  end

  // Phase sequencing; a pop loads the entry and snapshots TIMING for its whole cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    cs_n_d  = cs_n_q;
    wr_n_d  = wr_n_q;
    rs_d    = rs_q;
    data_d  = data_q;
    pop     = 1'b0;
`ifdef TFTLCD_PIXEL_REPEAT_EN
    rep_d   = rep_q;
`endif
    unique case (state_q)
      ST_IDLE: pop = ~empty;
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = phase_last(snap_q, STROBE_LSB);
          wr_n_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - tfield_t'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          cnt_d   = phase_last(snap_q, HOLD_LSB);
          wr_n_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - tfield_t'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - tfield_t'(1);
        end
`ifdef TFTLCD_PIXEL_REPEAT_EN
        else if (rep_q != '0) begin
          rep_d   = rep_q - REPEAT_W'(1);
          state_d = ST_SETUP;
          cnt_d   = phase_last(snap_q, SETUP_LSB);
        end
`endif
        else if (!empty) begin
          pop = 1'b1;
        end else begin
          state_d = ST_IDLE;
          cs_n_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (pop) begin
      state_d = ST_SETUP;
      snap_d  = timing_q;
      cnt_d   = phase_last(timing_q, SETUP_LSB);
      cs_n_d  = 1'b0;
      wr_n_d  = 1'b1;
      rs_d    = pop_rs;
      data_d  = pop_data;
`ifdef TFTLCD_PIXEL_REPEAT_EN
      rep_d   = (pop_cnt == '0) ? '0 : pop_cnt - REPEAT_W'(1);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      snap_q  <= TREG_W'(TIMING_RST);
      cs_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      rs_q    <= 1'b0;
      data_q  <= '0;
`ifdef TFTLCD_PIXEL_REPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      cs_n_q  <= cs_n_d;
      wr_n_q  <= wr_n_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
`ifdef TFTLCD_PIXEL_REPEAT_EN
      rep_q   <= rep_d;
`endif
    end
  end

  assign lcd_cs_n = cs_n_q;
  assign lcd_wr_n = wr_n_q;
  assign lcd_rs   = rs_q;
  assign lcd_data = data_q;
  assign lcd_rd_n = 1'b1;

endmodule

// File: tb/tb_ed2_tftlcd_bus_writer.sv
// Self-checking bench for ed2_tftlcd_bus_writer: register table, LCD cycle monitor and queue-based model.
`timescale 1ns/1ps
module tb_ed2_tftlcd_bus_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic        read_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        lcd_cs_n;
  logic        lcd_rs;
  logic        lcd_wr_n;
  logic        lcd_rd_n;
  logic [15:0] lcd_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ed2_tftlcd_bus_writer dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .read_n      (read_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .waitrequest (waitrequest),
    .lcd_cs_n    (lcd_cs_n),
    .lcd_rs      (lcd_rs),
    .lcd_wr_n    (lcd_wr_n),
    .lcd_rd_n    (lcd_rd_n),
    .lcd_data    (lcd_data)
  );

  typedef struct { logic rs; logic [15:0] data; } ent_t;
  typedef struct { logic rs; logic [15:0] data; int pre; int low; bit first; bit stable; } ev_t;
  typedef struct { logic [1:0] addr; bit is_wr; logic [31:0] wdata; logic [31:0] exp; } vec_t;

  ent_t exp_q[$];
  ev_t  ev_q[$];
  int   tail_q[$];
  int   rd_bad = 0;
  int   rep_next = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int nz(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  // LCD monitor: one event per strobe, plus the hold length at the end of each CS-low burst.
  int  m_pre = 0, m_low = 0;
  bit  m_first = 1, m_inburst = 0;
  ev_t m_ev;
  always @(negedge clk) begin
    if (lcd_rd_n !== 1'b1) rd_bad++;
    if (reset) begin
      m_pre = 0; m_low = 0; m_first = 1; m_inburst = 0;
    end else if (lcd_cs_n) begin
      if (m_inburst) tail_q.push_back(m_pre);
      m_pre = 0; m_low = 0; m_first = 1; m_inburst = 0;
    end else begin
      m_inburst = 1;
      if (!lcd_wr_n) begin
        if (m_low == 0) begin
          m_ev.rs = lcd_rs; m_ev.data = lcd_data; m_ev.pre = m_pre;
          m_ev.first = m_first; m_ev.stable = 1;
        end else if (lcd_rs !== m_ev.rs || lcd_data !== m_ev.data) begin
          m_ev.stable = 0;
        end
        m_low++;
      end else begin
        if (m_low > 0) begin
          m_ev.low = m_low;
          ev_q.push_back(m_ev);
          m_low = 0; m_pre = 0; m_first = 0;
        end
        m_pre++;
      end
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, output int stalls);
    ent_t e;
    int   k;
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    stalls = 0;
    #1;
    while (waitrequest && stalls < 5000) begin
      @(negedge clk); #1;
      stalls++;
    end
    if (stalls >= 5000) begin
      checks++; failures++;
      $display("FAIL write_timeout: waitrequest still 1 after %0d cycles, required 0", stalls);
    end
    @(posedge clk);
    if (a == 2'd0 || a == 2'd1) begin
      e.rs = a[0]; e.data = d[15:0];
      k = 1;
`ifdef TFTLCD_PIXEL_REPEAT_EN
      if (a == 2'd1) begin
        k = nz(rep_next);
        rep_next = 1;
      end
`endif
      repeat (k) exp_q.push_back(e);
    end
`ifdef TFTLCD_PIXEL_REPEAT_EN
    if (a == 2'd3) rep_next = int'(d[15:0]);
`endif
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    int s;
    bus_write(a, d, s);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read_n = 1'b0; address = a;
    #1;
    d = readdata;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic wait_drain(input int n);
    int cyc = 0;
    while ((ev_q.size() < n || !lcd_cs_n) && cyc < 20000) begin
      @(negedge clk); #1;
      cyc++;
    end
    if (cyc >= 20000) begin
      checks++; failures++;
      $display("FAIL drain_timeout: saw %0d strobes, required %0d", ev_q.size(), n);
    end
  endtask

  // Compare one observed strobe with the next model entry; exp_first < 0 means either.
  task automatic check_one(input string tag, input int exp_low, input int s, input int h,
                           input int exp_first);
    ev_t  ev;
    ent_t e;
    if (ev_q.size() == 0 || exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s_missing: strobes=%0d model=%0d, required both >0", tag, ev_q.size(), exp_q.size());
      return;
    end
    ev = ev_q.pop_front();
    e  = exp_q.pop_front();
    chk({tag, "_rs"}, 32'(ev.rs), 32'(e.rs));
    chk({tag, "_data"}, 32'(ev.data), 32'(e.data));
    chk({tag, "_wr_low"}, 32'(ev.low), 32'(exp_low));
    chk({tag, "_stable"}, 32'(ev.stable), 32'd1);
    if (exp_first >= 0) chk({tag, "_first"}, 32'(ev.first), 32'(exp_first));
    chk({tag, "_pre"}, 32'(ev.pre), 32'(ev.first ? nz(s) : nz(h) + nz(s)));
  endtask

  task automatic check_burst(input string tag, input int n, input int s, input int t, input int h,
                             input int bursts);
    int tl;
    wait_drain(n);
    for (int i = 0; i < n; i++) check_one(tag, nz(t), s, h, -1);
    chk({tag, "_leftover"}, 32'(ev_q.size()), 32'd0);
    if (bursts >= 0) chk({tag, "_bursts"}, 32'(tail_q.size()), 32'(bursts));
    while (tail_q.size() > 0) begin
      tl = tail_q.pop_front();
      chk({tag, "_hold"}, 32'(tl), 32'(nz(h)));
    end
  endtask

  vec_t vecs[8];
  logic [31:0] rd;
  int stalls;
  int cyc;
  logic [11:0] t;
  int n;

  initial begin
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
    address = '0; writedata = '0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(lcd_cs_n), 32'd1);
    chk("rst_wr_n", 32'(lcd_wr_n), 32'd1);
    chk("rst_rd_n", 32'(lcd_rd_n), 32'd1);
    chk("rst_rs", 32'(lcd_rs), 32'd0);
    chk("rst_data", 32'(lcd_data), 32'd0);
    chk("rst_waitreq", 32'(waitrequest), 32'd0);
    reset = 1'b0;

    vecs[0] = '{2'd2, 1'b0, 32'h0, 32'h112};
    vecs[1] = '{2'd3, 1'b0, 32'h0, 32'h0};
    vecs[2] = '{2'd0, 1'b0, 32'h0, 32'h0};
    vecs[3] = '{2'd1, 1'b0, 32'h0, 32'h0};
    vecs[4] = '{2'd2, 1'b1, 32'hFFFF_F5A7, 32'h0};
    vecs[5] = '{2'd2, 1'b0, 32'h0, 32'h5A7};
    vecs[6] = '{2'd2, 1'b1, 32'h112, 32'h0};
    vecs[7] = '{2'd2, 1'b0, 32'h0, 32'h112};
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].is_wr) wr(vecs[i].addr, vecs[i].wdata);
      else begin
        bus_read(vecs[i].addr, rd);
        chk($sformatf("reg_vec%0d", i), rd, vecs[i].exp);
      end
    end

    // Single command with default timing: 2 setup + 1 strobe + 1 hold.
    wr(2'd0, 32'h002C);
    wait_drain(1);
    check_one("cmd", 1, 2, 1, 1);
    chk("cmd_bursts", 32'(tail_q.size()), 32'd1);
    if (tail_q.size() > 0) chk("cmd_hold", 32'(tail_q.pop_front()), 32'd1);

    // TIMING change while the first entry strobes only affects the second entry.
    wr(2'd2, 32'h000);
    wr(2'd1, 32'hAAAA);
    wr(2'd1, 32'h5555);
    cyc = 0;
    while (lcd_wr_n && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk("tim_strobe_seen", 32'(lcd_wr_n), 32'd0);
    wr(2'd2, 32'h321);
    wait_drain(2);
    check_one("tim0", 1, 0, 0, 1);
    check_one("tim1", 2, 1, 1, 0);
    chk("tim_bursts", 32'(tail_q.size()), 32'd1);
    if (tail_q.size() > 0) chk("tim_hold", 32'(tail_q.pop_front()), 32'd3);

    // STATUS mid-burst with slow timing: one pop has happened after five pushes.
    wr(2'd2, 32'hFFF);
    for (int i = 0; i < 5; i++) wr(2'd1, 32'h2000 + 32'(i));
    bus_read(2'd3, rd);
    chk("status_mid", rd, {16'h0, 8'd4, 6'd0, 1'b0, 1'b1});
    check_burst("stat", 5, 15, 15, 15, 1);
    bus_read(2'd3, rd);
    chk("status_drained", rd, 32'h0);

    // Fill the FIFO; the 18th write stalls until the second pop frees a slot.
    for (int i = 0; i < 17; i++) wr(2'd1, 32'h1000 + 32'(i));
    bus_read(2'd3, rd);
    chk("status_full", rd, {16'h0, 8'd16, 6'd0, 1'b1, 1'b1});
    bus_write(2'd1, 32'h1000 + 32'd17, stalls);
    chk("stall_cycles", 32'(stalls), 32'd29);
    wr(2'd1, 32'h1000 + 32'd18);
    wr(2'd1, 32'h1000 + 32'd19);
    check_burst("fill", 20, 15, 15, 15, 1);

`ifdef TFTLCD_PIXEL_REPEAT_EN
    wr(2'd2, 32'h112);
    wr(2'd3, 32'd100);
    wr(2'd1, 32'hF800);
    wr(2'd1, 32'h001F);
    check_burst("rep", 101, 2, 1, 1, 1);
    wr(2'd3, 32'd50);
`endif

    // Reset while a long strobe is active; queued entries must vanish.
    wr(2'd2, 32'h0F0);
    for (int i = 0; i < 3; i++) wr(2'd1, 32'hBEE0 + 32'(i));
    cyc = 0;
    while (lcd_wr_n && cyc < 100) begin @(posedge clk); #1; cyc++; end
    chk("rst_mid_strobe_seen", 32'(lcd_wr_n), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    chk("rst_mid_cs_n", 32'(lcd_cs_n), 32'd1);
    chk("rst_mid_wr_n", 32'(lcd_wr_n), 32'd1);
    reset = 1'b0;
    ev_q.delete(); tail_q.delete(); exp_q.delete();
    rep_next = 1;
    bus_read(2'd3, rd);
    chk("rst_mid_status", rd, 32'h0);
    bus_read(2'd2, rd);
    chk("rst_mid_timing", rd, 32'h112);
    repeat (40) @(negedge clk);
    #1;
    chk("rst_mid_no_strobe", 32'(ev_q.size()), 32'd0);

    // Randomized traffic against the queue model with random timing.
    for (int r = 0; r < 3; r++) begin
      t = 12'($urandom_range(0, 12'hFFF));
      wr(2'd2, 32'(t));
      n = int'($urandom_range(5, 25));
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        wr(2'($urandom_range(0, 1)), $urandom);
      end
      check_burst($sformatf("rnd%0d", r), n, int'(t[3:0]), int'(t[7:4]), int'(t[11:8]), -1);
    end

    chk("rd_n_always_high", 32'(rd_bad), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
